// File: rtl/hamming_codec_arbiter_if.sv
// rtl/hamming_codec_arbiter_if.sv - requester, response and codec signals of the codec arbiter
// The slave modport is the arbiter's view; the master modport is the requesters/codec side.
interface hamming_codec_arbiter_if;
    logic       a_valid;
    logic       b_valid;
    logic       a_mode;
    logic       b_mode;
    logic [7:0] a_data;
    logic [7:0] b_data;
    logic       a_ready;
    logic       b_ready;
    logic       a_rsp_valid;
    logic       b_rsp_valid;
    logic       a_rsp_ready;
    logic       b_rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_err;
    logic       cdc_start;
    logic       cdc_mode;
    logic [7:0] cdc_data;
    logic       cdc_done;
    logic [7:0] cdc_result;
    logic [1:0] cdc_err;
    logic       busy;

    modport slave (
        input  a_valid, b_valid, a_mode, b_mode, a_data, b_data,
        input  a_rsp_ready, b_rsp_ready,
        input  cdc_done, cdc_result, cdc_err,
        output a_ready, b_ready, a_rsp_valid, b_rsp_valid, rsp_data, rsp_err,
        output cdc_start, cdc_mode, cdc_data, busy
    );

    modport master (
        output a_valid, b_valid, a_mode, b_mode, a_data, b_data,
        output a_rsp_ready, b_rsp_ready,
        output cdc_done, cdc_result, cdc_err,
        input  a_ready, b_ready, a_rsp_valid, b_rsp_valid, rsp_data, rsp_err,
        input  cdc_start, cdc_mode, cdc_data, busy
    );
endinterface

// File: rtl/hamming_codec_arbiter.sv
// rtl/hamming_codec_arbiter.sv - round-robin arbiter sharing one Hamming codec between two requesters
// One job in flight at a time: IDLE grants, ISSUE pulses the codec, WAIT times out, RESP returns the result.
module hamming_codec_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    hamming_codec_arbiter_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // WAIT lasts at most TIMEOUT cycles; the counter reads TIMEOUT-1 on the last one.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    logic       mode_q, mode_d;
    logic [7:0] data_q, data_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [1:0] rsp_err_q, rsp_err_d;

    logic       any_valid;
    logic       grant_b;
    logic       sel_mode;
    logic [7:0] sel_data;
    logic       owner_rsp_ready;
    logic       in_cdc;

    // Owner/last-served encoding: 0 = A, 1 = B. B only wins a tie when A was served last.
    assign any_valid       = bus.a_valid | bus.b_valid;
    assign grant_b         = bus.b_valid & (~bus.a_valid | ~last_q);
    assign sel_mode        = grant_b ? bus.b_mode : bus.a_mode;
    assign sel_data        = grant_b ? bus.b_data : bus.a_data;
    assign owner_rsp_ready = owner_q ? bus.b_rsp_ready : bus.a_rsp_ready;
    assign in_cdc          = (state_q == ISSUE) || (state_q == WAIT);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        mode_d     = mode_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    owner_d = grant_b;
                    mode_d  = sel_mode;
                    data_d  = sel_mode ? sel_data : {4'h0, sel_data[3:0]};
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 8'h00;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 8'h01;
                if (bus.cdc_done) begin
                    rsp_data_d = bus.cdc_result;
                    rsp_err_d  = bus.cdc_err;
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = 8'h00;
                    rsp_err_d  = 2'b11;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            mode_q     <= 1'b0;
            data_q     <= 8'h00;
            cnt_q      <= 8'h00;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Ready is the only combinational output; gating with rst_n keeps it low while in reset.
    assign bus.a_ready     = rst_n & (state_q == IDLE) & bus.a_valid & ~grant_b;
    assign bus.b_ready     = rst_n & (state_q == IDLE) & grant_b;
    assign bus.a_rsp_valid = (state_q == RESP) & ~owner_q;
    assign bus.b_rsp_valid = (state_q == RESP) & owner_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.cdc_start   = (state_q == ISSUE);
    assign bus.cdc_mode    = in_cdc & mode_q;
    assign bus.cdc_data    = in_cdc ? data_q : 8'h00;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_hamming_codec_arbiter.sv
// tb/tb_hamming_codec_arbiter.sv - self-checking bench for hamming_codec_arbiter
// Directed and random jobs against a transaction-level model of grant order, latency and result.
module tb_hamming_codec_arbiter;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   exp_last = 1'b1;

    int         cd_lat = 0;
    int         cd_cnt = 0;
    logic [7:0] cd_res = 8'h00;
    logic [1:0] cd_err = 2'b00;
    bit         cd_noise = 1'b0;

    hamming_codec_arbiter_if bus ();

    hamming_codec_arbiter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Codec stand-in: done pulses on the cd_lat-th WAIT cycle after a start (0 = never).
    always @(negedge clk) begin
        if (!rst_n) begin
            cd_cnt         = 0;
            bus.cdc_done   = 1'b0;
            bus.cdc_result = 8'h00;
            bus.cdc_err    = 2'b00;
        end else if (cd_noise) begin
            bus.cdc_done   = 1'($urandom);
            bus.cdc_result = 8'($urandom);
            bus.cdc_err    = 2'($urandom);
        end else if (bus.cdc_start) begin
            cd_cnt       = cd_lat;
            bus.cdc_done = 1'b0;
        end else if (cd_cnt > 0) begin
            cd_cnt         = cd_cnt - 1;
            bus.cdc_done   = (cd_cnt == 0);
            bus.cdc_result = cd_res;
            bus.cdc_err    = cd_err;
        end else begin
            bus.cdc_done = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: a tie goes to whoever was not served last, a lone request always wins.
    function automatic bit pick(input bit av, input bit bv, input bit last);
        if (av && bv) return ~last;
        return bv;
    endfunction

    function automatic logic [31:0] all_outs();
        return {7'h0, bus.a_ready, bus.b_ready, bus.a_rsp_valid, bus.b_rsp_valid, bus.busy,
                bus.cdc_start, bus.cdc_mode, bus.cdc_data, bus.rsp_data, bus.rsp_err};
    endfunction

    // Called and returns at a negedge with the DUT in IDLE.
    task automatic run_job(input bit av, input bit bv, input bit am, input bit bm,
                           input logic [7:0] ad, input logic [7:0] bd, input int lat,
                           input logic [7:0] res, input logic [1:0] err, input int hold,
                           input bit keep, input bit noise);
        bit         w;
        bit         m;
        bit         ok;
        logic [7:0] xd;
        logic [7:0] xr;
        logic [1:0] xe;
        int         waits;
        int         cyc;

        w  = pick(av, bv, exp_last);
        m  = w ? bm : am;
        xd = w ? bd : ad;
        if (!m) xd = {4'h0, xd[3:0]};
        if (lat >= 1 && lat <= TMO) begin
            xr = res; xe = err; waits = lat;
        end else begin
            xr = 8'h00; xe = 2'b11; waits = TMO;
        end

        bus.a_valid = av; bus.b_valid = bv;
        bus.a_mode  = am; bus.b_mode  = bm;
        bus.a_data  = ad; bus.b_data  = bd;
        cd_lat = lat; cd_res = res; cd_err = err;
        #1;
        chk("grant_a_ready", {31'h0, bus.a_ready}, {31'h0, !w});
        chk("grant_b_ready", {31'h0, bus.b_ready}, {31'h0, w});

        @(negedge clk);
        chk("issue_start", {31'h0, bus.cdc_start}, 32'd1);
        chk("issue_data", {24'h0, bus.cdc_data}, {24'h0, xd});
        chk("issue_mode", {31'h0, bus.cdc_mode}, {31'h0, m});
        chk("issue_ready_low", {30'h0, bus.a_ready, bus.b_ready}, 32'd0);
        if (!keep) begin
            if (w) bus.b_valid = 1'b0;
            else   bus.a_valid = 1'b0;
        end

        ok  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!(bus.a_rsp_valid || bus.b_rsp_valid)) begin
                if (bus.cdc_start || bus.cdc_data !== xd || bus.cdc_mode !== m ||
                    bus.a_ready || bus.b_ready || !bus.busy) ok = 1'b0;
            end
        end while (!(bus.a_rsp_valid || bus.b_rsp_valid) && cyc < 200);
        chk("wait_stable", {31'h0, ok}, 32'd1);
        chk("latency", cyc, waits + 1);
        chk("rsp_owner", {30'h0, bus.a_rsp_valid, bus.b_rsp_valid}, w ? 32'd1 : 32'd2);
        chk("rsp_data", {24'h0, bus.rsp_data}, {24'h0, xr});
        chk("rsp_err", {30'h0, bus.rsp_err}, {30'h0, xe});

        ok = 1'b1;
        cd_noise = noise;
        for (int i = 0; i < hold; i++) begin
            if (w) bus.a_rsp_ready = 1'($urandom);
            else   bus.b_rsp_ready = 1'($urandom);
            @(negedge clk);
            if (bus.rsp_data !== xr || bus.rsp_err !== xe || bus.cdc_start ||
                bus.a_ready || bus.b_ready ||
                {bus.a_rsp_valid, bus.b_rsp_valid} !== (w ? 2'b01 : 2'b10)) ok = 1'b0;
        end
        cd_noise = 1'b0;
        if (hold > 0) chk("hold_stable", {31'h0, ok}, 32'd1);

        if (w) bus.b_rsp_ready = 1'b1;
        else   bus.a_rsp_ready = 1'b1;
        @(negedge clk);
        bus.a_rsp_ready = 1'b0;
        bus.b_rsp_ready = 1'b0;
        chk("back_to_idle", {29'h0, bus.busy, bus.a_rsp_valid, bus.b_rsp_valid}, 32'd0);
        exp_last = w;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.a_valid     = 1'b1;
        bus.b_valid     = 1'b1;
        bus.a_mode      = 1'b0;
        bus.b_mode      = 1'b0;
        bus.a_data      = 8'h00;
        bus.b_data      = 8'h00;
        bus.a_rsp_ready = 1'b0;
        bus.b_rsp_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 32'd0);
        rst_n = 1'b1;

        // Simultaneous requests from reset, both held: A, B, A, B.
        run_job(1, 1, 0, 1, 8'h3C, 8'hA5, 2, 8'h71, 2'b00, 1, 1, 0);
        run_job(1, 1, 0, 1, 8'h3C, 8'hA5, 4, 8'h62, 2'b01, 0, 1, 0);
        run_job(1, 1, 1, 0, 8'hE1, 8'h9D, 1, 8'h13, 2'b10, 2, 1, 0);
        run_job(1, 1, 1, 0, 8'hE1, 8'h9D, 3, 8'h24, 2'b00, 0, 0, 0);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;

        // Single A encode job with a held response.
        run_job(1, 0, 0, 0, 8'h0B, 8'h00, 3, 8'h55, 2'b00, 4, 0, 0);
        // Codec never answers: timeout after TMO WAIT cycles.
        run_job(1, 0, 1, 0, 8'hC4, 8'h00, 0, 8'hEE, 2'b01, 1, 0, 0);
        // Done on the very cycle the timeout fires wins.
        run_job(1, 0, 1, 0, 8'h5F, 8'h00, TMO, 8'hA3, 2'b01, 1, 0, 0);
        // B owns the result, A pending, done/a_rsp_ready toggling for 10 cycles.
        run_job(1, 1, 0, 1, 8'h77, 8'hC7, 2, 8'h4E, 2'b10, 10, 0, 1);
        run_job(1, 0, 0, 0, 8'h77, 8'h00, 1, 8'h5A, 2'b01, 0, 0, 0);

        // Reset during WAIT with B pending.
        bus.a_valid = 1'b1; bus.a_mode = 1'b1; bus.a_data = 8'h96;
        bus.b_valid = 1'b0; cd_lat = 0;
        @(negedge clk);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b1; bus.b_mode = 1'b0; bus.b_data = 8'h3E;
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy", {31'h0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", all_outs(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        exp_last = 1'b1;
        run_job(0, 1, 0, 0, 8'h00, 8'h3E, 2, 8'h11, 2'b10, 1, 0, 0);
        run_job(1, 0, 1, 0, 8'h96, 8'h00, 5, 8'h29, 2'b00, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            int v;
            v = int'($urandom_range(1, 3));
            run_job(v[0], v[1], 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, TMO + 2)), 8'($urandom), 2'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hamming_codec_arbiter.md
HAMMING_CODEC_ARBITER -- requirements
Module: hamming_codec_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, the maximum number of WAIT cycles before a transaction is aborted (range 1..255).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports a_valid, b_valid  input  1 each  requester A/B has a job pending.
REQ-005 The block SHALL have ports a_mode, b_mode  input  1 each  0 = encode, 1 = decode.
REQ-006 The block SHALL have ports a_data, b_data  input  8 each  job payload (encode uses [3:0] only).
REQ-007 The block SHALL have ports a_ready, b_ready  output  1 each  job accepted this cycle when valid & ready.
REQ-008 The block SHALL have ports a_rsp_valid, b_rsp_valid  output  1 each  result available to requester A/B.
REQ-009 The block SHALL have ports a_rsp_ready, b_rsp_ready  input  1 each  requester A/B consumes its result.
REQ-010 The block SHALL have ports rsp_data  output  8  and  rsp_err  output  2, a single result bus shared by both requesters.
REQ-011 The block SHALL have ports cdc_start  output  1,  cdc_mode  output  1,  cdc_data  output  8, which drive the shared codec.
REQ-012 The block SHALL have ports cdc_done  input  1,  cdc_result  input  8,  cdc_err  input  2, which return the codec completion.
REQ-013 The block SHALL have port busy  output  1, high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-015 IDLE SHALL behave as follows: if either valid is high, grant one requester, drive its ready high combinationally in that cycle, latch its mode and data plus an owner flag, and go to ISSUE; otherwise remain in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; with one valid, grant it regardless of history.
REQ-017 The last-served flag SHALL reset to B, so A wins the first simultaneous request.
REQ-018 Ready SHALL be high only in IDLE, and only for the granted requester.
REQ-019 In ISSUE, cdc_start SHALL be high for exactly one cycle, and the FSM SHALL then go to WAIT.
REQ-020 cdc_mode and cdc_data SHALL be held stable from ISSUE until the FSM leaves WAIT.
REQ-021 In encode mode, cdc_data SHALL equal {4'b0, data[3:0]}; in decode mode it SHALL equal the full 8-bit data.
REQ-022 In WAIT, an 8-bit cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-023 On cdc_done in WAIT, the block SHALL capture cdc_result and cdc_err into rsp_data/rsp_err and go to RESP.
REQ-024 If the counter reaches TIMEOUT without cdc_done, the block SHALL set rsp_data=8'h00 and rsp_err=2'b11 and go to RESP.
REQ-025 If cdc_done and the timeout occur in the same cycle, cdc_done SHALL take priority.
REQ-026 cdc_done SHALL be ignored in IDLE, ISSUE and RESP.
REQ-027 In RESP, only the owner's rsp_valid SHALL be high, and rsp_data/rsp_err SHALL be held stable until the owner's rsp_ready is sampled high.
REQ-028 On the RESP handshake, the block SHALL update last-served to the owner and return to IDLE; the earliest new grant is the following cycle.
REQ-029 rsp_ready of the non-owner SHALL be ignored.
REQ-030 End-to-end latency SHALL be accept -> ISSUE (1 cycle) -> WAIT (≥1 cycle) -> RESP, i.e. codec latency + 2 cycles minimum.
REQ-031 New requests arriving in ISSUE, WAIT or RESP SHALL stay pending (ready low) and SHALL NOT be lost.

Reset
REQ-032 While rst_n is low, the block SHALL force state=IDLE, counter=0, last-served=B, all outputs 0 (rsp_data 8'h00, rsp_err 2'b00, cdc_* 0, ready/rsp_valid/busy 0).
REQ-033 Reset asserted mid-transaction SHALL drop that transaction with no response; after release the block SHALL resume arbitration from IDLE.

Verification
REQ-034 A only: a_valid, mode 0, a_data=8'h0B -> a_ready one cycle, cdc_data=8'h0B, cdc_start one cycle; codec returns done with 8'h55/2'b00 -> a_rsp_valid, rsp_data=8'h55, rsp_err=00, held until a_rsp_ready.
REQ-035 Contention: A and B valid together from reset -> A served first, then B; with both held valid continuously, grants alternate A,B,A,B.
REQ-036 Timeout: TIMEOUT=15, cdc_done never asserted -> RESP entered after the 15th WAIT cycle with rsp_data=8'h00, rsp_err=2'b11.
REQ-037 Done on the timeout cycle: done asserted with 8'hA3/2'b01 on the cycle the counter hits TIMEOUT -> rsp_data=8'hA3, rsp_err=2'b01.
REQ-038 Back-pressure: hold b_rsp_ready low 10 cycles in RESP while toggling a_rsp_ready and cdc_done -> outputs stable, a_ready stays 0, no new cdc_start.
REQ-039 Mid-transaction reset: assert rst_n low during WAIT -> all outputs 0 asynchronously; after release a pending B is granted before A.
